nes_tetris_soc_keycode_fifo: RTL
================================

Name: nes_tetris_soc_keycode_fifo

Overview:
Parametrised successor to the single-register keycode output port. The Avalon-MM slave (Nios II side) pushes keycodes into a DEPTH-entry FIFO. Game logic drains the FIFO through a valid/ready stream, so no keypress is lost between frames. A legacy out_port mirrors the last written keycode. Status and control registers expose fill level, a sticky overflow flag, consumer enable and flush.

Parameters:
WIDTH, 8, keycode width in bits (1..16)
DEPTH, 4, FIFO entries; power of two, 2..128
(local) CNT_W = clog2(DEPTH)+1, occupancy counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  Avalon word address
chipselect  in  1  Avalon chip select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data; combinational, zero wait states
out_port  out  WIDTH  last keycode written to address 0
key_valid  out  1  FIFO head valid to consumer
key_data  out  WIDTH  FIFO head keycode
key_ready  in  1  consumer accepts head

Behaviour:
- One clock domain; all state is async-cleared on reset_n low.
- Reset values: rd_ptr=0, wr_ptr=0, count=0, overflow=0, enable=1, last=0.
- Reset output values: out_port=0, key_valid=0, key_data=mem[0] (don't-care), readdata follows address.
- wr = chipselect & ~write_n.
- Register map, readdata zero-extended:
  - addr0 W: push writedata[WIDTH-1:0] and set last to that value. R: last.
  - addr1 R: bit0 empty, bit1 full, bit2 overflow, bits[8+CNT_W-1:8] count. W: writedata[2]=1 clears overflow (W1C); other bits ignored.
  - addr2 R: bit0 enable, bit1 reads 0. W: bit0 -> enable; bit1=1 flushes (self-clearing strobe).
  - addr3: reads 0, writes ignored.
- last updates on every addr0 write, including dropped pushes; out_port = last.
- FIFO is show-ahead:
  - key_data = mem[rd_ptr].
  - key_valid = enable & (count != 0), combinational from registers.
  - pop = key_valid & key_ready; data is transferred on that edge.
- Latency: a push written at edge N gives key_valid=1 after edge N (1 cycle) if the FIFO was empty and enable=1.
- push_ok = push & (count<DEPTH | pop):
  - Push when full with a same-cycle pop is accepted; count is unchanged.
  - Push when full without a pop is dropped, overflow<=1, memory and pointers unchanged.
- count update: +1 on push_ok & ~pop; -1 on pop & ~push_ok; otherwise held.
- Pointers wrap modulo DEPTH (log2(DEPTH) bits); the count distinguishes full from empty.
- Flush (addr2 write with bit1=1):
  - rd_ptr<=0, wr_ptr<=0, count<=0 next edge.
  - Same-cycle pop is ignored. overflow and enable are unaffected, except that enable takes writedata[0] from the same write.
  - Only one Avalon access per cycle, so flush and push never coincide.
- Overflow W1C and an overflow-setting event in the same cycle cannot occur (single Avalon port). If a future master makes them coincide, set wins.
- enable=0 forces key_valid=0; the FIFO still accepts pushes and holds its contents.
- key_ready while key_valid=0 has no effect.
- Reset mid-operation discards all entries immediately (async); key_valid drops combinationally.

Test Plan:
1. Reset, then read addr0/1/2 -> 0x0, 0x1 (empty, count 0), 0x1; out_port=0, key_valid=0.
2. With key_ready=0, write 0x1A, 0x2B, 0x3C to addr0 -> addr1 reads 0x0300. Then key_ready=1 -> key_data 0x1A, 0x2B, 0x3C on consecutive cycles, then key_valid=0. out_port=0x3C throughout.
3. DEPTH=4, key_ready=0, push 0x01..0x05 -> addr1=0x0406 (full+overflow, count 4), out_port=0x05. Drain gives 0x01..0x04. Write 0x4 to addr1 -> overflow reads 0.
4. Full FIFO, hold key_ready=1 and push 0x77 the same cycle -> count stays 4, no overflow. 0x77 emerges 4th after the pop.
5. Push 0x10, 0x20, then write addr2=0x0 -> key_valid=0, count 2 retained. Write addr2=0x1 -> 0x10 presented.
6. Push 3 entries, write addr2=0x3 (flush+enable) -> next cycle count=0, key_valid=0. Next push 0x55 appears at key_data (pointers reset to 0).

Source files
------------

// File: rtl/nes_tetris_soc_keycode_fifo_if.sv
// Bus bundle for the keycode FIFO: Avalon-MM register port from the Nios II
// side plus the valid/ready keycode stream toward the game logic.
interface nes_tetris_soc_keycode_fifo_if #(
   parameter int WIDTH = 8
);
   logic [1:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic             key_valid;
   logic [WIDTH-1:0] key_data;
   logic             key_ready;

   // FIFO block side
   modport slave (
      input  address, chipselect, write_n, writedata, key_ready,
      output readdata, key_valid, key_data
   );

   // System side: CPU bus master and stream consumer
   modport master (
      output address, chipselect, write_n, writedata, key_ready,
      input  readdata, key_valid, key_data
   );
endinterface

// File: rtl/nes_tetris_soc_keycode_fifo.sv
// Keycode FIFO: CPU pushes keycodes through an Avalon-MM slave, game logic
// drains them through a show-ahead valid/ready stream. out_port keeps the
// legacy "last keycode written" behaviour.
module nes_tetris_soc_keycode_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   nes_tetris_soc_keycode_fifo_if.slave bus,
   output logic [WIDTH-1:0]             out_port
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             enable;
   logic [WIDTH-1:0] last;

   logic wr;
   logic push;
   logic status_wr;
   logic control_wr;
   logic flush;
   logic empty;
   logic full;
   logic pop;
   logic push_ok;
   logic unused_writedata;

   assign wr         = bus.chipselect & ~bus.write_n;
   assign push       = wr & (bus.address == 2'd0);
   assign status_wr  = wr & (bus.address == 2'd1);
   assign control_wr = wr & (bus.address == 2'd2);
   assign flush      = control_wr & bus.writedata[1];

   assign empty = (count == '0);
   assign full  = (count == FULL_COUNT);

   // Head is presented straight from the pointed-to entry, gated by enable
   assign bus.key_valid = enable & ~empty;
   assign bus.key_data  = mem[rd_ptr];
   assign pop           = bus.key_valid & bus.key_ready;

   // A full FIFO still takes a push when the head leaves in the same cycle
   assign push_ok = push & (~full | pop);

   assign out_port = last;

   // Only a slice of writedata is meaningful at any given address
   assign unused_writedata = ^bus.writedata;

   // Storage: no reset, contents are only meaningful below count
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= bus.writedata[WIDTH-1:0];
      end
   end

   // Pointers and occupancy; flush overrides any same-cycle pop
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push_ok) begin
            count <= count - 1'b1;
         end
      end
   end

   // Control/status registers; a dropped push beats a same-cycle W1C clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
         enable   <= 1'b1;
         last     <= '0;
      end else begin
         if (push) begin
            last <= bus.writedata[WIDTH-1:0];
         end
         if (push && !push_ok) begin
            overflow <= 1'b1;
         end else if (status_wr && bus.writedata[2]) begin
            overflow <= 1'b0;
         end
         if (control_wr) begin
            enable <= bus.writedata[0];
         end
      end
   end

   // Zero-wait-state register readback, zero-extended
   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         2'd0: bus.readdata[WIDTH-1:0] = last;
         2'd1: begin
            bus.readdata[0]           = empty;
            bus.readdata[1]           = full;
            bus.readdata[2]           = overflow;
            bus.readdata[8 +: CNT_W]  = count;
         end
         2'd2: bus.readdata[0] = enable;
         default: bus.readdata = '0;
      endcase
   end
endmodule
